// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter constants and helpers (up and down counters)
package counter_pkg;

    localparam int CNT_WIDTH_MAX       = 16;
    localparam int CNT_WIDTH_DEFAULT   = 4;
    localparam int CNT_MODULUS_DEFAULT = 16;

    // True when the modulus uses every code of the register, so wrap is a natural overflow.
    function automatic bit cnt_full_range(input int width, input int modulus);
        return modulus == (1 << width);
    endfunction

endpackage

// File: rtl/sync_up_counter_if.sv
// rtl/sync_up_counter_if.sv - counter control/status bundle; load/d exist only with COUNT_LOAD_EN
interface sync_up_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
);

    logic             en;
`ifdef COUNT_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] d;
`endif
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;

    modport master (
        output en,
`ifdef COUNT_LOAD_EN
        output load,
        output d,
`endif
        input  q,
        input  q_bar,
        input  tc
    );

    modport slave (
        input  en,
`ifdef COUNT_LOAD_EN
        input  load,
        input  d,
`endif
        output q,
        output q_bar,
        output tc
    );

endinterface

// File: rtl/sync_up_counter_jk_cell.sv
// rtl/sync_up_counter_jk_cell.sv - synchronous JK flip-flop with synchronous active-high reset
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - synchronous modulo-N up counter built from jk_cell bits
// Optional parallel load is compiled in with COUNT_LOAD_EN.
module sync_up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH_DEFAULT,
    parameter int MODULUS = CNT_MODULUS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    sync_up_counter_if.slave  cnt
);

    localparam bit               FULL  = cnt_full_range(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] load_val;
    logic             do_load;
    logic             at_term;

`ifdef COUNT_LOAD_EN
    assign do_load  = cnt.load;
    assign load_val = ({1'b0, cnt.d} < MOD_W) ? cnt.d : '0;
`else
    assign do_load  = 1'b0;
    assign load_val = '0;
`endif

    assign at_term = (q == TERM);

    // Toggle chain: bit i flips when enabled and every lower bit is 1.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        if (gi == 0) begin : g_lsb
            assign chain[gi] = cnt.en;
        end else begin : g_upper
            assign chain[gi] = cnt.en & (&q[gi-1:0]);
        end
    end

    // Load and short-modulus clear drive J/K as explicit set/clear; otherwise toggle.
    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (do_load) begin
                j[i] = load_val[i];
                k[i] = ~load_val[i];
            end else if (!FULL && cnt.en && at_term) begin
                j[i] = 1'b0;
                k[i] = 1'b1;
            end else begin
                j[i] = chain[i];
                k[i] = chain[i];
            end
        end
    end

    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[gb]),
            .k     (k[gb]),
            .q     (q[gb]),
            .q_bar (q_bar[gb])
        );
    end

    assign cnt.q     = q;
    assign cnt.q_bar = q_bar;
    assign cnt.tc    = cnt.en & at_term;

endmodule

// File: tb/tb_sync_up_counter.sv
// tb/tb_sync_up_counter.sv - randomized and directed checks of sync_up_counter against an arithmetic model
module tb_sync_up_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r0 = 1'b1, e0 = 1'b0, l0 = 1'b0;
    logic [3:0] d0 = '0;
    logic       r1 = 1'b1, e1 = 1'b0, l1 = 1'b0;
    logic [3:0] d1 = '0;
    logic       rc = 1'b1, ec = 1'b0;

    int m0, m1, mc;
    int checks = 0;
    int errors = 0;

    sync_up_counter_if #(.WIDTH(4)) if0 ();
    sync_up_counter_if #(.WIDTH(4)) if1 ();
    sync_up_counter_if #(.WIDTH(4)) ifc_lo ();
    sync_up_counter_if #(.WIDTH(4)) ifc_hi ();

    assign if0.en    = e0;
    assign if1.en    = e1;
    assign ifc_lo.en = ec;
    assign ifc_hi.en = ifc_lo.tc;
`ifdef COUNT_LOAD_EN
    assign if0.load    = l0;
    assign if0.d       = d0;
    assign if1.load    = l1;
    assign if1.d       = d1;
    assign ifc_lo.load = 1'b0;
    assign ifc_lo.d    = '0;
    assign ifc_hi.load = 1'b0;
    assign ifc_hi.d    = '0;
`endif

    sync_up_counter #(.WIDTH(4), .MODULUS(16)) dut0  (.clk(clk), .reset(r0), .cnt(if0));
    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut1  (.clk(clk), .reset(r1), .cnt(if1));
    sync_up_counter #(.WIDTH(4), .MODULUS(16)) dut_lo (.clk(clk), .reset(rc), .cnt(ifc_lo));
    sync_up_counter #(.WIDTH(4), .MODULUS(16)) dut_hi (.clk(clk), .reset(rc), .cnt(ifc_hi));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_val(input int q, input int modulus, input logic r,
                                    input logic e, input logic l, input int d);
        if (r)      return 0;
        if (l)      return (d < modulus) ? d : 0;
        if (e)      return (q + 1) % modulus;
        return q;
    endfunction

    // Checks the present state, then advances one edge and the models with it.
    task automatic tick();
        #1;
        check("q0",     if0.q,     m0);
        check("qbar0",  if0.q_bar, (~m0) & 15);
        check("tc0",    if0.tc,    (e0 && m0 == 15) ? 1 : 0);
        check("q1",     if1.q,     m1);
        check("qbar1",  if1.q_bar, (~m1) & 15);
        check("tc1",    if1.tc,    (e1 && m1 == 9) ? 1 : 0);
        check("casc",   {ifc_hi.q, ifc_lo.q}, mc % 256);
        @(posedge clk);
        m0 = next_val(m0, 16, r0, e0, l0, int'(d0));
        m1 = next_val(m1, 10, r1, e1, l1, int'(d1));
        mc = rc ? 0 : (ec ? mc + 1 : mc);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        m0 = 0; m1 = 0; mc = 0;
        rc = 1'b0; ec = 1'b1;

        // Reset held with en high keeps everything at zero.
        e0 = 1'b1; e1 = 1'b1;
        repeat (2) tick();

        // Free-running count: 0..15 wraps on dut0, 0..9 wraps on dut1.
        r0 = 1'b0; r1 = 1'b0;
        repeat (20) tick();
        check("free20_q0", if0.q, 4);
        check("free20_q1", if1.q, 0);

        // Bring dut0 to 7, hold with en low, then resume.
        r0 = 1'b1; tick();
        r0 = 1'b0; repeat (7) tick();
        e0 = 1'b0; repeat (5) tick();
        check("hold7", if0.q, 7);
        e0 = 1'b1; tick();
        check("resume8", if0.q, 8);

        // Reset mid-count at 12 with en still high.
        repeat (4) tick();
        check("at12", if0.q, 12);
        r0 = 1'b1; tick();
        check("rst_q", if0.q, 0);
        check("rst_qbar", if0.q_bar, 15);
        tick();
        r0 = 1'b0;

        for (int n = 0; n < 200; n++) begin
            r0 = ($urandom_range(0, 19) == 0);
            e0 = ($urandom_range(0, 9) < 7);
            r1 = ($urandom_range(0, 19) == 0);
            e1 = ($urandom_range(0, 9) < 7);
`ifdef COUNT_LOAD_EN
            l0 = ($urandom_range(0, 9) == 0);
            d0 = 4'($urandom_range(0, 15));
            l1 = ($urandom_range(0, 9) == 0);
            d1 = 4'($urandom_range(0, 15));
`endif
            tick();
        end
        r0 = 1'b0; r1 = 1'b0; l0 = 1'b0; l1 = 1'b0; e0 = 1'b1; e1 = 1'b1;

`ifdef COUNT_LOAD_EN
        l1 = 1'b1; d1 = 4'd6; tick();
        check("load6", if1.q, 6);
        d1 = 4'd12; tick();
        check("load12", if1.q, 0);
        d1 = 4'd5; r1 = 1'b1; tick();
        check("load_rst", if1.q, 0);
        l1 = 1'b0; r1 = 1'b0;
`endif

        // Let the cascaded pair reach 300 enabled edges.
        for (int guard = 0; guard < 400 && mc < 300; guard++) tick();
        check("casc_mc", mc, 300);
        check("casc300", {ifc_hi.q, ifc_lo.q}, 44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_up_counter.md
SYNC_UP_COUNTER -- requirements
Module: sync_up_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter bit width (2..16).
REQ-002 The block SHALL have parameter MODULUS, default 16, meaning count states, wrap after MODULUS-1 (2..2**WIDTH).
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on rising edge only.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port load  input  1  parallel-load strobe (present only with COUNT_LOAD_EN).
REQ-007 The block SHALL have port d  input  WIDTH  parallel-load value (present only with COUNT_LOAD_EN).
REQ-008 The block SHALL have port q  output  WIDTH  count value.
REQ-009 The block SHALL have port q_bar  output  WIDTH  bitwise complement of q.
REQ-010 The block SHALL have port tc  output  1  terminal count, cascade carry.

Function
REQ-011 All q bits SHALL change on the same clk edge: fully synchronous up counter, no bit clocked from another bit's output.
REQ-012 With en=1 and q<MODULUS-1, next q SHALL be q+1.
REQ-013 With en=1 and q==MODULUS-1, next q SHALL be 0 (wrap-around).
REQ-014 With en=0 and no load, q SHALL hold.
REQ-015 q_bar SHALL equal ~q at every cycle, including reset.
REQ-016 tc SHALL be combinational: 1 exactly when en=1 and q==MODULUS-1, else 0.
REQ-017 Latency from en sampled high to q update SHALL be one clk cycle.
REQ-018 For MODULUS==2**WIDTH, bit i SHALL toggle when en and all lower bits are 1 (JK toggle chain, J=K=en AND q[i-1:0]).
REQ-019 For MODULUS<2**WIDTH, the terminal state SHALL force a synchronous clear to 0, never an asynchronous one; the terminal state SHALL be visible for a full cycle.

Reset
REQ-020 Priority SHALL be reset > load > en.
REQ-021 On reset, q SHALL be 0, q_bar SHALL be all ones and tc SHALL be 0, regardless of en/load.
REQ-022 Reset asserted mid-count SHALL clear q at the next edge; counting SHALL resume from 0 on the first edge after reset deasserts with en=1.

Configuration
REQ-023 Macro COUNT_LOAD_EN SHALL control the parallel load.
REQ-024 With COUNT_LOAD_EN defined, load=1 SHALL set next q to d if d<MODULUS, else to 0; load overrides en in the same cycle and tc follows the new q.
REQ-025 Without COUNT_LOAD_EN, ports load and d SHALL be absent and the count SHALL be modified only by reset and en.

Structure
REQ-026 Package counter_pkg SHALL hold CNT_WIDTH_MAX=16 and the default WIDTH/MODULUS constants, shared with the existing down counter.
REQ-027 One sub-module, jk_cell, SHALL be used per bit: a synchronous JK flip-flop with synchronous reset and q/q_bar outputs, all instances on the common clk.
REQ-028 Next-state, wrap and load muxing SHALL live in sync_up_counter, driving each jk_cell's J/K.

Verification
REQ-029 Reset, then en=1 for 20 cycles (defaults) -> q = 0,1,...,15,0,1,2,3; tc=1 only while q=15; q_bar=~q throughout.
REQ-030 MODULUS=10, en=1 for 12 cycles -> q = 0..9,0,1; tc high only at q=9; q never reaches 10.
REQ-031 q=7, en=0 for 5 cycles -> q holds 7 and tc=0; en=1 -> q=8 next edge.
REQ-032 reset=1 while q=12 and en=1 -> q=0, q_bar=4'hF, tc=0 next edge; reset and en=1 together keep q=0.
REQ-033 COUNT_LOAD_EN, MODULUS=10: load=1, d=6, en=1 -> q=6 next edge; d=12 -> q=0; load=1 with reset=1 -> q=0.
REQ-034 Two instances cascaded via tc->en (defaults), en=1 for 300 cycles -> combined 8-bit value = 300 mod 256 = 44; all bits update on the same edge.
